// File: rtl/hamming_encoder_tx.sv
// Hamming(7,4) encoder with optional single-bit error injection and a
// framed serial transmitter. Each accepted nibble becomes a 7-bit codeword
// (code[6] = Hamming position 1) that is shifted out MSB first, followed by
// IDLE_GAP idle cycles before the next nibble can be taken.
module hamming_encoder_tx #(
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] err_pos,
    output logic [6:0] code_out,
    output logic       serial_out,
    output logic       serial_valid,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned FC_W   = 8;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CODE_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [CODE_W-1:0] code_q,      code_d;
    logic [CODE_W-1:0] shreg_q,     shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
    logic [FC_W-1:0]   fcount_q,    fcount_d;
    logic              ser_q,       ser_d;
    logic              ser_vld_q,   ser_vld_d;
    logic              fstart_q,    fstart_d;

    logic [CODE_W-1:0] codeword;

    // Systematic Hamming(7,4): parity at positions 1,2,4 (code[6],code[5],code[3])
    function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c[6] = d[3] ^ d[2] ^ d[0];
        c[5] = d[3] ^ d[1] ^ d[0];
        c[4] = d[3];
        c[3] = d[2] ^ d[1] ^ d[0];
        c[2] = d[2];
        c[1] = d[1];
        c[0] = d[0];
        return c;
    endfunction

    // Hamming position p (1..7) maps to code[7-p]; 0 leaves the word intact
    function automatic logic [CODE_W-1:0] error_mask(input logic [BIT_W-1:0] p);
        logic [CODE_W-1:0] m;
        case (p)
            3'd1:    m = 7'b1000000;
            3'd2:    m = 7'b0100000;
            3'd3:    m = 7'b0010000;
            3'd4:    m = 7'b0001000;
            3'd5:    m = 7'b0000100;
            3'd6:    m = 7'b0000010;
            3'd7:    m = 7'b0000001;
            default: m = '0;
        endcase
        return m;
    endfunction

    assign codeword = hamming_encode(data_in) ^ error_mask(err_pos);

    // Ready only while idle and out of reset, so reset also blocks accepts
    assign in_ready = (state_q == S_IDLE) && !rst;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        fcount_d  = fcount_q;
        ser_d     = 1'b0;
        ser_vld_d = 1'b0;
        fstart_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    code_d    = codeword;
                    shreg_d   = codeword;
                    bit_cnt_d = '0;
                    ser_d     = codeword[CODE_W-1];
                    ser_vld_d = 1'b1;
                    fstart_d  = 1'b1;
                    state_d   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    fcount_d  = fcount_q + 8'd1;
                    gap_cnt_d = '0;
                    state_d   = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
                end else begin
                    shreg_d   = {shreg_q[CODE_W-2:0], 1'b0};
                    ser_d     = shreg_q[CODE_W-2];
                    ser_vld_d = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides any accept or shift
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            fcount_q  <= '0;
            ser_q     <= 1'b0;
            ser_vld_q <= 1'b0;
            fstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            fcount_q  <= fcount_d;
            ser_q     <= ser_d;
            ser_vld_q <= ser_vld_d;
            fstart_q  <= fstart_d;
        end
    end

    assign code_out     = code_q;
    assign serial_out   = ser_q;
    assign serial_valid = ser_vld_q;
    assign frame_start  = fstart_q;
    assign frame_count  = fcount_q;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Randomized self-checking bench for hamming_encoder_tx. Two instances:
// A with IDLE_GAP=1 and B with IDLE_GAP=0. Expected codewords come from a
// position-based Hamming model (parity = XOR over positions whose index has
// the parity bit set; syndrome = XOR of indices of set bits).
module tb_hamming_encoder_tx;

    logic       clk = 1'b0;
    logic       rst_a, vin_a, rdy_a, so_a, sv_a, fs_a;
    logic       rst_b, vin_b, rdy_b, so_b, sv_b, fs_b;
    logic [3:0] din_a, din_b;
    logic [2:0] ep_a, ep_b;
    logic [6:0] code_a, code_b;
    logic [7:0] fc_a, fc_b;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mfc_a = 8'd0;
    logic [7:0] mfc_b = 8'd0;

    always #5 clk = ~clk;

    hamming_encoder_tx #(.IDLE_GAP(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .data_in(din_a), .in_valid(vin_a),
        .in_ready(rdy_a), .err_pos(ep_a), .code_out(code_a),
        .serial_out(so_a), .serial_valid(sv_a), .frame_start(fs_a),
        .frame_count(fc_a)
    );

    hamming_encoder_tx #(.IDLE_GAP(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .data_in(din_b), .in_valid(vin_b),
        .in_ready(rdy_b), .err_pos(ep_b), .code_out(code_b),
        .serial_out(so_b), .serial_valid(sv_b), .frame_start(fs_b),
        .frame_count(fc_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hamming position i (1..7) is code bit 7-i
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [7:1] pos;
        logic       par;
        logic [6:0] c;
        pos    = '0;
        pos[3] = d[3];
        pos[5] = d[2];
        pos[6] = d[1];
        pos[7] = d[0];
        for (int k = 0; k < 3; k++) begin
            par = 1'b0;
            for (int i = 1; i <= 7; i++)
                if (((i >> k) & 1) == 1 && i != (1 << k)) par ^= pos[i];
            pos[1 << k] = par;
        end
        for (int i = 1; i <= 7; i++) c[7-i] = pos[i];
        return c;
    endfunction

    function automatic logic [2:0] ref_syndrome(input logic [6:0] c);
        logic [2:0] s;
        s = '0;
        for (int i = 1; i <= 7; i++)
            if (c[7-i]) s ^= 3'(i);
        return s;
    endfunction

    function automatic logic [6:0] ref_inject(input logic [6:0] c, input logic [2:0] p);
        logic [6:0] r;
        r = c;
        if (p != 3'd0) r[7 - int'(p)] = ~r[7 - int'(p)];
        return r;
    endfunction

    function automatic logic [6:0] ref_correct(input logic [6:0] c);
        return ref_inject(c, ref_syndrome(c));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        for (int w = 0; w < 64 && !rdy_a; w++) tick();
        check("ready_wait_a", rdy_a, 1);
    endtask

    // One frame on A with garbage driven during SHIFT; returns code_out
    task automatic send_frame_a(input logic [3:0] d, input logic [2:0] p, output logic [6:0] got);
        logic [6:0] exp;
        exp = ref_inject(ref_encode(d), p);
        wait_ready_a();
        din_a = d; ep_a = p; vin_a = 1'b1;
        tick();
        for (int j = 0; j < 7; j++) begin
            check("ser_bit", so_a, exp[6-j]);
            check("ser_valid", sv_a, 1);
            check("frame_start", fs_a, (j == 0) ? 1 : 0);
            check("ready_busy", rdy_a, 0);
            check("code_out", code_a, exp);
            din_a = 4'($urandom); ep_a = 3'($urandom);
            vin_a = (j < 6);
            if (j < 6) tick();
        end
        tick();
        mfc_a++;
        check("post_valid", sv_a, 0);
        check("post_fstart", fs_a, 0);
        check("post_ser", so_a, 0);
        check("frame_count", fc_a, mfc_a);
        check("code_hold", code_a, exp);
        got = code_a;
    endtask

    // Holds in_valid high with random data; checks period, ignore-while-busy, count
    task automatic run_b2b(input bit sel, input int period, input int nframes);
        logic [6:0] exp;
        logic [3:0] d;
        logic [2:0] p;
        int         j;
        exp = '0;
        for (int w = 0; w < 64 && !(sel ? rdy_b : rdy_a); w++) tick();
        check("b2b_ready", sel ? rdy_b : rdy_a, 1);
        for (int c = 0; c <= nframes * period; c++) begin
            j = c % period;
            if (c > 0) tick();
            check("b2b_in_ready", sel ? rdy_b : rdy_a, (j == 0) ? 1 : 0);
            check("b2b_valid", sel ? sv_b : sv_a, (j >= 1 && j <= 7) ? 1 : 0);
            check("b2b_fstart", sel ? fs_b : fs_a, (j == 1) ? 1 : 0);
            if (j >= 1 && j <= 7) begin
                check("b2b_ser_bit", sel ? so_b : so_a, exp[7-j]);
                check("b2b_code", sel ? code_b : code_a, exp);
            end
            if (j != 7) check("b2b_count", sel ? fc_b : fc_a, sel ? mfc_b : mfc_a);
            if (j == 7) begin
                if (sel) mfc_b++;
                else     mfc_a++;
            end
            d = 4'($urandom);
            p = 3'($urandom_range(0, 7));
            if (sel) begin din_b = d; ep_b = p; vin_b = (c < nframes * period); end
            else     begin din_a = d; ep_a = p; vin_a = (c < nframes * period); end
            if (j == 0 && c < nframes * period) exp = ref_inject(ref_encode(d), p);
        end
        vin_a = 1'b0;
        vin_b = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] got;
        logic [6:0] exp;
        logic [3:0] d;
        logic [2:0] p;

        rst_a = 1'b1; vin_a = 1'b0; din_a = '0; ep_a = '0;
        rst_b = 1'b1; vin_b = 1'b0; din_b = '0; ep_b = '0;
        repeat (3) tick();
        check("rst_code", code_a, 0);
        check("rst_ser", so_a, 0);
        check("rst_valid", sv_a, 0);
        check("rst_fstart", fs_a, 0);
        check("rst_count", fc_a, 0);
        check("rst_ready", rdy_a, 0);
        rst_a = 1'b0;
        #1;
        check("ready_after_release", rdy_a, 1);

        // Abort a frame with reset at the 4th serial bit
        exp = ref_encode(4'b0110);
        din_a = 4'b0110; ep_a = 3'd0; vin_a = 1'b1;
        tick();
        vin_a = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        check("abort_bit4", so_a, exp[3]);
        check("abort_bit4_valid", sv_a, 1);
        rst_a = 1'b1;
        tick();
        check("abort_code", code_a, 0);
        check("abort_ser", so_a, 0);
        check("abort_valid", sv_a, 0);
        check("abort_fstart", fs_a, 0);
        check("abort_count", fc_a, 0);
        check("abort_ready", rdy_a, 0);
        rst_a = 1'b0;
        #1;
        check("abort_release_ready", rdy_a, 1);

        // Reference frame 1011 -> 0110011
        send_frame_a(4'b1011, 3'd0, got);
        check("frame_1011", got, 7'b0110011);
        check("frame_1011_count", fc_a, 1);

        // All nibbles, no injection
        for (int n = 0; n < 16; n++) begin
            send_frame_a(4'(n), 3'd0, got);
            check("zero_syndrome", ref_syndrome(got), 0);
            if (n == 0)  check("code_h0", got, 7'h00);
            if (n == 15) check("code_hF", got, 7'h7F);
            if (n == 1)  check("code_h1", got, 7'h69);
        end

        // Injection at position 3
        send_frame_a(4'b1011, 3'd3, got);
        check("inject3_code", got, 7'b0100011);
        check("inject3_syndrome", ref_syndrome(got), 3);
        check("inject3_corrected", ref_correct(got), 7'b0110011);

        // Random nibbles and injection positions
        for (int r = 0; r < 30; r++) begin
            d = 4'($urandom);
            p = 3'($urandom_range(0, 7));
            send_frame_a(d, p, got);
            check("rand_syndrome", ref_syndrome(got), p);
            check("rand_corrected", ref_correct(got), ref_encode(d));
        end

        // Back-to-back with one gap cycle: period 9
        run_b2b(1'b0, 9, 6);

        // IDLE_GAP=0: period 8, 256 frames wrap the counter
        tick();
        rst_b = 1'b0;
        #1;
        check("b_ready_after_release", rdy_b, 1);
        check("b_count_reset", fc_b, 0);
        run_b2b(1'b1, 8, 256);
        check("wrap_count", fc_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
